systolic_pe_mac: RTL and testbench
==================================

// Module: systolic_pe_mac
// PURPOSE
//   Parametrised output-stationary MAC processing element for the systolic array; successor to the fixed 32-bit PE.
//   Operands A (west->east) and B (north->south) are registered and forwarded with valid bits.
//   The accumulator sums A*B when both operands are valid, with signed/unsigned and saturating options.
//   Finished results are captured into a result register and shifted out over a per-column drain chain.
// PARAMETERS
//   DW      16  operand width (A, B)
//   AW      40  accumulator/result width; must be >= 2*DW
//   SIGNED  1   1: two's-complement operands/accumulator; 0: unsigned
//   SAT     1   1: clamp accumulator on overflow; 0: wrap modulo 2^AW
// PORTS
//   clk          in   1   clock; all registers update on rising edge
//   clr          in   1   synchronous, active-high reset
//   a_in         in   DW  A operand from west neighbour
//   a_vld_in     in   1   a_in valid
//   b_in         in   DW  B operand from north neighbour
//   b_vld_in     in   1   b_in valid
//   a_out        out  DW  registered A to east neighbour
//   a_vld_out    out  1   registered a_vld_in
//   b_out        out  DW  registered B to south neighbour
//   b_vld_out    out  1   registered b_vld_in
//   done         in   1   tile end: capture accumulator into result register
//   shift        in   1   drain-chain shift enable (shared per column)
//   sum_in       in   AW  result from upstream PE in drain chain
//   sum_vld_in   in   1   sum_in valid
//   sum_out      out  AW  registered drain output
//   sum_vld_out  out  1   sum_out valid
//   ovf          out  1   sticky overflow/saturation flag
// BEHAVIOUR
//   - Reset (clr=1 at edge): a_out, b_out, sum_out, acc, res = 0; all valid bits 0; ovf = 0. clr beats every other input, including mid-tile and mid-drain.
//   - Forwarding: a_out<=a_in, a_vld_out<=a_vld_in, b_out<=b_in, b_vld_out<=b_vld_in every cycle. Latency 1; no stalls.
//   - Data is forwarded even when its valid bit is 0.
//   - MAC: when a_vld_in & b_vld_in, acc <= acc + ext(a_in*b_in).
//     - Product is 2*DW bits, sign-/zero-extended to AW per SIGNED.
//     - If only one valid is high, acc holds.
//   - Overflow: the sum is computed at AW+1 bits.
//     - SAT=1: clamp to max/min representable AW value.
//     - SAT=0: wrap.
//     - In both cases, an out-of-range sum sets ovf. ovf is sticky until clr.
//   - done: res <= value acc would take this cycle, including any simultaneous MAC. res_vld <= 1; acc <= 0 (same edge).
//   - shift: sum_out <= res, sum_vld_out <= res_vld; res <= sum_in, res_vld <= sum_vld_in.
//     - shift=0: sum_out and sum_vld_out hold.
//   - done & shift in the same cycle: sum_out takes the old res; res takes the new capture (done wins over sum_in).
//   - States (per PE): ACCUM (acc live) -> done -> RESULT (res_vld=1) -> shift -> res takes upstream data.
//     - ACCUM continues in parallel with RESULT, so the next tile overlaps the drain.
//     - res_vld is internal only; it is observable via sum_vld_out.
// TESTING (DW=8, AW=20, SIGNED=1, SAT=1 unless noted)
//   1. clr 1 cycle; A=5,B=2 both valid 1 cycle -> next edge a_out=5, b_out=2, valids 1. Then done, then shift -> sum_out=10, sum_vld_out=1.
//   2. Pairs (3,4),(-2,7),(10,10), all valid, then done+shift sequence -> sum_out=98. Repeat with SIGNED=0 and operand 0xFE in place of -2 -> 12+1778+100=1890.
//   3. a_vld_in=1, b_vld_in=0, A=9 -> a_vld_out=1, b_vld_out=0, acc unchanged (later drain shows 0).
//   4. 127*127 x33 cycles -> res=524287 (clamped), ovf=1. SAT=0 variant: res=532257-1048576=-516319, ovf=1.
//   5. 3-PE chain with results 1,2,3 (upstream->downstream), shift x3 -> last sum_out sequence 3,2,1. Final sum_vld_out follows chain-head sum_vld_in=0.
//   6. clr asserted mid-accumulation and mid-drain -> all outputs and ovf 0 on next edge. done+MAC in the same cycle -> res includes that product, acc=0.

Source files
------------

// File: rtl/systolic_pe_mac.sv
// Output-stationary MAC processing element: forwards A east and B south, accumulates A*B,
// captures tile results and shifts them out over a per-column drain chain.
module systolic_pe_mac #(
  parameter int DW     = 16,
  parameter int AW     = 40,
  parameter int SIGNED = 1,
  parameter int SAT    = 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [DW-1:0] a_in,
  input  logic          a_vld_in,
  input  logic [DW-1:0] b_in,
  input  logic          b_vld_in,
  output logic [DW-1:0] a_out,
  output logic          a_vld_out,
  output logic [DW-1:0] b_out,
  output logic          b_vld_out,
  input  logic          done,
  input  logic          shift,
  input  logic [AW-1:0] sum_in,
  input  logic          sum_vld_in,
  output logic [AW-1:0] sum_out,
  output logic          sum_vld_out,
  output logic          ovf
);
  localparam int   PW = 2 * DW;
  localparam logic SG = (SIGNED != 0);
  localparam logic ST = (SAT != 0);

  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic          a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic [AW-1:0] acc_q, acc_d, res_q, res_d, sum_q, sum_d;
  logic          res_vld_q, res_vld_d, sum_vld_q, sum_vld_d, ovf_q, ovf_d;

  logic [PW-1:0] a_ext, b_ext, prod;
  logic [AW:0]   prod_x, acc_x, sum_x;
  logic [AW-1:0] sat_val, acc_mac;
  logic          mac, oor;

  always_comb begin
    // Extending operands to the product width lets one multiplier serve both signednesses.
    a_ext  = {{DW{SG & a_in[DW-1]}}, a_in};
    b_ext  = {{DW{SG & b_in[DW-1]}}, b_in};
    prod   = a_ext * b_ext;
    prod_x = {{(AW+1-PW){SG & prod[PW-1]}}, prod};
    acc_x  = {SG & acc_q[AW-1], acc_q};
    sum_x  = acc_x + prod_x;
    oor    = SG ? (sum_x[AW] ^ sum_x[AW-1]) : sum_x[AW];
    if (SG) sat_val = sum_x[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    else    sat_val = '1;

    mac     = a_vld_in & b_vld_in;
    acc_mac = acc_q;
    if (mac) acc_mac = (ST && oor) ? sat_val : sum_x[AW-1:0];

    a_d       = a_in;
    a_vld_d   = a_vld_in;
    b_d       = b_in;
    b_vld_d   = b_vld_in;
    ovf_d     = ovf_q | (mac & oor);
    acc_d     = acc_mac;
    res_d     = res_q;
    res_vld_d = res_vld_q;
    sum_d     = sum_q;
    sum_vld_d = sum_vld_q;

    if (shift) begin
      sum_d     = res_q;
      sum_vld_d = res_vld_q;
      res_d     = sum_in;
      res_vld_d = sum_vld_in;
    end
    // A capture overrides upstream drain data; the old result still leaves via sum_out.
    if (done) begin
      res_d     = acc_mac;
      res_vld_d = 1'b1;
      acc_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      a_q       <= '0;
      a_vld_q   <= 1'b0;
      b_q       <= '0;
      b_vld_q   <= 1'b0;
      acc_q     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      sum_q     <= '0;
      sum_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      a_q       <= a_d;
      a_vld_q   <= a_vld_d;
      b_q       <= b_d;
      b_vld_q   <= b_vld_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      sum_q     <= sum_d;
      sum_vld_q <= sum_vld_d;
      ovf_q     <= ovf_d;
    end
  end

  assign a_out       = a_q;
  assign a_vld_out   = a_vld_q;
  assign b_out       = b_q;
  assign b_vld_out   = b_vld_q;
  assign sum_out     = sum_q;
  assign sum_vld_out = sum_vld_q;
  assign ovf         = ovf_q;
endmodule

// File: tb/tb_systolic_pe_mac.sv
// Bench for systolic_pe_mac: three configs (signed/sat, unsigned/sat, signed/wrap) driven in
// lockstep, checked against an integer-arithmetic reference model plus directed values.
module tb_systolic_pe_mac;
  localparam int DW = 8;
  localparam int AW = 20;
  localparam int NI = 3;

  logic          clk;
  logic          clr, a_vld_in, b_vld_in, done, shift, sum_vld_in;
  logic [DW-1:0] a_in, b_in;
  logic [AW-1:0] sum_in;
  logic [DW-1:0] a_out [NI];
  logic [DW-1:0] b_out [NI];
  logic [AW-1:0] sum_out [NI];
  logic          a_vld_out [NI];
  logic          b_vld_out [NI];
  logic          sum_vld_out [NI];
  logic          ovf [NI];

  // instance 0: SIGNED=1 SAT=1, instance 1: SIGNED=0 SAT=1, instance 2: SIGNED=1 SAT=0
  for (genvar g = 0; g < NI; g++) begin : g_dut
    systolic_pe_mac #(.DW(DW), .AW(AW), .SIGNED(g != 1), .SAT(g != 2)) u_pe (
      .clk(clk), .clr(clr),
      .a_in(a_in), .a_vld_in(a_vld_in), .b_in(b_in), .b_vld_in(b_vld_in),
      .a_out(a_out[g]), .a_vld_out(a_vld_out[g]), .b_out(b_out[g]), .b_vld_out(b_vld_out[g]),
      .done(done), .shift(shift), .sum_in(sum_in), .sum_vld_in(sum_vld_in),
      .sum_out(sum_out[g]), .sum_vld_out(sum_vld_out[g]), .ovf(ovf[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // reference model state, values held as plain integers in each config's number range
  longint        m_acc [NI];
  longint        m_res [NI];
  longint        m_so  [NI];
  logic          m_rv  [NI];
  logic          m_sv  [NI];
  logic          m_ovf [NI];
  logic [DW-1:0] m_a, m_b;
  logic          m_av, m_bv;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint to_val(input int i, input logic [AW-1:0] v);
    if (i != 1) return longint'($signed(v));
    return longint'(v);
  endfunction

  function automatic longint opv(input int i, input logic [DW-1:0] v);
    if (i != 1) return longint'($signed(v));
    return longint'(v);
  endfunction

  task automatic model_step();
    longint s, lo, hi, acc_n;
    logic [63:0] sb;
    for (int i = 0; i < NI; i++) begin
      if (clr) begin
        m_acc[i] = 0; m_res[i] = 0; m_so[i] = 0;
        m_rv[i] = 1'b0; m_sv[i] = 1'b0; m_ovf[i] = 1'b0;
      end else begin
        acc_n = m_acc[i];
        if (a_vld_in && b_vld_in) begin
          s  = m_acc[i] + opv(i, a_in) * opv(i, b_in);
          lo = (i != 1) ? -(64'sd1 <<< (AW-1)) : 64'sd0;
          hi = (i != 1) ? (64'sd1 <<< (AW-1)) - 1 : (64'sd1 <<< AW) - 1;
          if (s < lo || s > hi) begin
            m_ovf[i] = 1'b1;
            if (i != 2) s = (s < lo) ? lo : hi;
            else begin
              sb = s;
              s  = to_val(i, sb[AW-1:0]);
            end
          end
          acc_n = s;
        end
        if (shift) begin
          m_so[i]  = m_res[i];
          m_sv[i]  = m_rv[i];
          m_res[i] = to_val(i, sum_in);
          m_rv[i]  = sum_vld_in;
        end
        if (done) begin
          m_res[i] = acc_n;
          m_rv[i]  = 1'b1;
          m_acc[i] = 0;
        end else m_acc[i] = acc_n;
      end
    end
    m_a  = clr ? '0 : a_in;
    m_b  = clr ? '0 : b_in;
    m_av = clr ? 1'b0 : a_vld_in;
    m_bv = clr ? 1'b0 : b_vld_in;
  endtask

  task automatic compare();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("a_out%0d", i), longint'(a_out[i]), longint'(m_a));
      chk($sformatf("a_vld%0d", i), longint'(a_vld_out[i]), longint'(m_av));
      chk($sformatf("b_out%0d", i), longint'(b_out[i]), longint'(m_b));
      chk($sformatf("b_vld%0d", i), longint'(b_vld_out[i]), longint'(m_bv));
      chk($sformatf("sum_out%0d", i), to_val(i, sum_out[i]), m_so[i]);
      chk($sformatf("sum_vld%0d", i), longint'(sum_vld_out[i]), longint'(m_sv[i]));
      chk($sformatf("ovf%0d", i), longint'(ovf[i]), longint'(m_ovf[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic op(input logic [DW-1:0] ia, input logic [DW-1:0] ib, input logic iav,
                    input logic ibv, input logic idn, input logic ish,
                    input logic [AW-1:0] isum = '0, input logic isv = 1'b0);
    clr = 1'b0; a_in = ia; b_in = ib; a_vld_in = iav; b_vld_in = ibv;
    done = idn; shift = ish; sum_in = isum; sum_vld_in = isv;
    step();
  endtask

  task automatic do_clr();
    clr = 1'b1; a_in = '0; b_in = '0; a_vld_in = 1'b0; b_vld_in = 1'b0;
    done = 1'b0; shift = 1'b0; sum_in = '0; sum_vld_in = 1'b0;
    step();
    clr = 1'b0;
  endtask

  initial begin
    do_clr();
    chk("rst_sum", to_val(0, sum_out[0]), 0);
    chk("rst_ovf", longint'(ovf[0]), 0);

    // single product, forwarding latency 1, capture then drain
    op(8'd5, 8'd2, 1, 1, 0, 0);
    chk("t1_a_out", longint'(a_out[0]), 5);
    chk("t1_b_out", longint'(b_out[0]), 2);
    op(8'd0, 8'd0, 0, 0, 1, 0);
    op(8'd0, 8'd0, 0, 0, 0, 1);
    chk("t1_sum", to_val(0, sum_out[0]), 10);
    chk("t1_vld", longint'(sum_vld_out[0]), 1);

    // mixed-sign pairs; 0xFE is -2 signed, 254 unsigned
    do_clr();
    op(8'd3, 8'd4, 1, 1, 0, 0);
    op(8'hFE, 8'd7, 1, 1, 0, 0);
    op(8'd10, 8'd10, 1, 1, 0, 0);
    op(8'd0, 8'd0, 0, 0, 1, 0);
    op(8'd0, 8'd0, 0, 0, 0, 1);
    chk("t2_signed", to_val(0, sum_out[0]), 98);
    chk("t2_unsigned", to_val(1, sum_out[1]), 1890);

    // only one operand valid: accumulator holds
    do_clr();
    op(8'd9, 8'd3, 1, 0, 0, 0);
    chk("t3_a_vld", longint'(a_vld_out[0]), 1);
    chk("t3_b_vld", longint'(b_vld_out[0]), 0);
    op(8'd0, 8'd0, 0, 0, 1, 0);
    op(8'd0, 8'd0, 0, 0, 0, 1);
    chk("t3_sum", to_val(0, sum_out[0]), 0);

    // 127*127 x33 overflows the signed 20-bit range
    do_clr();
    for (int k = 0; k < 33; k++) op(8'd127, 8'd127, 1, 1, 0, 0);
    op(8'd0, 8'd0, 0, 0, 1, 0);
    op(8'd0, 8'd0, 0, 0, 0, 1);
    chk("t4_sat", to_val(0, sum_out[0]), 524287);
    chk("t4_sat_ovf", longint'(ovf[0]), 1);
    chk("t4_wrap", to_val(2, sum_out[2]), -516319);
    chk("t4_wrap_ovf", longint'(ovf[2]), 1);
    chk("t4_uns_ovf", longint'(ovf[1]), 0);

    // drain chain ordering as seen from one PE
    do_clr();
    op(8'd1, 8'd1, 1, 1, 1, 0);
    op(8'd0, 8'd0, 0, 0, 0, 1, 20'd2, 1);
    chk("t5_first", to_val(0, sum_out[0]), 1);
    op(8'd0, 8'd0, 0, 0, 0, 1, 20'd3, 1);
    chk("t5_second", to_val(0, sum_out[0]), 2);
    op(8'd0, 8'd0, 0, 0, 0, 1, 20'd0, 0);
    chk("t5_third", to_val(0, sum_out[0]), 3);
    op(8'd0, 8'd0, 0, 0, 0, 1, 20'd0, 0);
    chk("t5_tail_vld", longint'(sum_vld_out[0]), 0);

    // done with a simultaneous MAC, then done & shift together, then clr mid-drain
    do_clr();
    op(8'd3, 8'd4, 1, 1, 0, 0);
    op(8'd2, 8'd5, 1, 1, 1, 0);
    op(8'd1, 8'd6, 1, 1, 1, 1, 20'd77, 1);
    chk("t6_done_mac", to_val(0, sum_out[0]), 22);
    op(8'd0, 8'd0, 0, 0, 0, 1);
    chk("t6_done_shift", to_val(0, sum_out[0]), 6);
    op(8'd100, 8'd100, 1, 1, 0, 0);
    do_clr();
    chk("t6_clr_sum", to_val(0, sum_out[0]), 0);
    chk("t6_clr_vld", longint'(sum_vld_out[0]), 0);
    chk("t6_clr_a", longint'(a_out[0]), 0);

    // randomized traffic with extreme operands and occasional clr
    for (int n = 0; n < 2000; n++) begin
      clr        = ($urandom_range(63) == 0);
      a_in       = ($urandom_range(3) == 0) ? ($urandom_range(1) ? 8'h7F : 8'h80) : 8'($urandom);
      b_in       = ($urandom_range(3) == 0) ? ($urandom_range(1) ? 8'h7F : 8'h80) : 8'($urandom);
      a_vld_in   = ($urandom_range(3) != 0);
      b_vld_in   = ($urandom_range(3) != 0);
      done       = ($urandom_range(15) == 0);
      shift      = ($urandom_range(2) == 0);
      sum_in     = 20'($urandom);
      sum_vld_in = 1'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
